// File: rtl/sr_lsu.sv
// sr_lsu: load/store unit between an sr_cpu-class core and a single-outstanding
// valid/ready memory port. Handles byte/half/word(/dword) sizes, sign/zero
// extension, byte write strobes, lane steering and an error return.
// Optional feature macro: SR_LSU_MISALIGN_TRAP_EN (misaligned accesses complete
// with err_o=1 and no memory request; otherwise low address bits are cleared
// and err_o is always 0).
module sr_lsu #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_wr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_resp_valid_i,
  output logic              mem_resp_ready_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t              r_state;
  logic                r_wr;
  logic                r_unsigned;
  logic [LB-1:0]       r_off;
  logic [LB-1:0]       r_mask;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [NB-1:0]       r_wstrb;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  // Effective size: sizes wider than the bus collapse to the full bus width.
  logic [1:0]          w_eff;
  logic [LB-1:0]       w_mask;   // low address bits covered by one access
  logic [LB-1:0]       w_off;    // aligned byte offset within the bus word
  logic [NB-1:0]       w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_shifted;
  logic                w_sign;
  logic [DATA_W-1:0]   w_load;
  logic                w_trap;

  assign w_eff = (int'(req_size_i) > LB) ? 2'(LB) : req_size_i;

  genvar gi;
  generate
    for (gi = 0; gi < LB; gi++) begin : g_mask
      assign w_mask[gi] = (w_eff > 2'(gi));
    end
  endgenerate

  assign w_off = req_addr_i[LB-1:0] & ~w_mask;

`ifdef SR_LSU_MISALIGN_TRAP_EN
  assign w_trap = |(req_addr_i[LB-1:0] & w_mask);
`else
  assign w_trap = 1'b0;
`endif

  // Lane steering: a lane is written when it falls inside the aligned window,
  // and every lane carries the right-aligned store data repeated per size.
  generate
    for (gi = 0; gi < NB; gi++) begin : g_store_lane
      localparam logic [LB-1:0] LANE = LB'(gi);
      logic [LB-1:0] w_src;
      assign w_src                = LANE & w_mask;
      assign w_wstrb[gi]          = req_wr_i & ((LANE & ~w_mask) == w_off);
      assign w_wdata[8*gi +: 8]   = req_wdata_i[{w_src, 3'b000} +: 8];
    end
  endgenerate

  // Load path: bring the addressed lane down to bit 0, then extend above it.
  assign w_shifted = mem_rdata_i >> {r_off, 3'b000};
  assign w_sign    = ~r_unsigned & w_shifted[{r_mask, 3'b111}];

  generate
    for (gi = 0; gi < NB; gi++) begin : g_load_lane
      localparam logic [LB-1:0] LANE = LB'(gi);
      assign w_load[8*gi +: 8] = ((LANE & ~r_mask) == '0) ? w_shifted[8*gi +: 8]
                                                          : {8{w_sign}};
    end
  endgenerate

  // Control FSM with registered request/response data; handshake strobes decode from state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr       <= 1'b0;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_mask     <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_wr       <= req_wr_i;
            r_unsigned <= req_unsigned_i;
            r_off      <= w_off;
            r_mask     <= w_mask;
            r_rdata    <= '0;
            r_err      <= w_trap;
            r_mem_wr   <= req_wr_i & ~w_trap;
            r_mem_addr <= w_trap ? '0 : {req_addr_i[ADDR_W-1:LB], LB'(0)};
            r_wstrb    <= w_trap ? '0 : w_wstrb;
            r_wdata    <= w_trap ? '0 : w_wdata;
            r_state    <= w_trap ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready_i) r_state <= S_RESP;
        end
        S_RESP: begin
          if (mem_resp_valid_i) begin
            r_rdata <= r_wr ? '0 : w_load;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = (r_state == S_DONE);
  assign mem_req_valid_o  = (r_state == S_REQ);
  assign mem_resp_ready_o = (r_state == S_RESP);
  assign rdata_o          = r_rdata;
  assign err_o            = r_err;
  assign mem_wr_o         = r_mem_wr;
  assign mem_addr_o       = r_mem_addr;
  assign mem_wstrb_o      = r_wstrb;
  assign mem_wdata_o      = r_wdata;

endmodule

// File: tb/tb_sr_lsu.sv
// Directed testbench for sr_lsu (default parameters, ADDR_W=16, DATA_W=32).
module tb_sr_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_wr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [15:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_wr_o;
  logic [15:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sr_lsu #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_wr_i         (req_wr_i),
    .req_size_i       (req_size_i),
    .req_unsigned_i   (req_unsigned_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .rdata_o          (rdata_o),
    .err_o            (err_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_wr_o         (mem_wr_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wstrb_o      (mem_wstrb_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_rdata_i      (mem_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access with best-case or stalled request handshake.
  task automatic run_txn(input string tag, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int stall,
                         input logic [15:0] exp_addr, input logic [3:0] exp_wstrb,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = wr; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    @(negedge clk);
    check({tag, ".busy"},  64'(busy_o), 64'd1);
    check({tag, ".rqv"},   64'(mem_req_valid_o), 64'd1);
    check({tag, ".wr"},    64'(mem_wr_o), 64'(wr));
    check({tag, ".addr"},  64'(mem_addr_o), 64'(exp_addr));
    check({tag, ".wstrb"}, 64'(mem_wstrb_o), 64'(exp_wstrb));
    check({tag, ".wdata"}, 64'(mem_wdata_o), 64'(exp_wdata));
    for (int s = 0; s < stall; s++) begin
      mem_resp_valid_i = (s == 0);
      mem_rdata_i = 32'hDEAD_0000;
      @(negedge clk);
      mem_resp_valid_i = 1'b0;
      check({tag, ".stall_rqv"},   64'(mem_req_valid_o), 64'd1);
      check({tag, ".stall_addr"},  64'(mem_addr_o), 64'(exp_addr));
      check({tag, ".stall_wdata"}, 64'(mem_wdata_o), 64'(exp_wdata));
      check({tag, ".stall_wstrb"}, 64'(mem_wstrb_o), 64'(exp_wstrb));
      check({tag, ".stall_done"},  64'(done_o), 64'd0);
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    check({tag, ".rsp_rdy"}, 64'(mem_resp_ready_o), 64'd1);
    check({tag, ".rsp_rqv"}, 64'(mem_req_valid_o), 64'd0);
    check({tag, ".rsp_done"}, 64'(done_o), 64'd0);
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = rdata;
    @(negedge clk);
    mem_resp_valid_i = 1'b0; req_valid_i = 1'b0;
    check({tag, ".done"},  64'(done_o), 64'd1);
    check({tag, ".dbusy"}, 64'(busy_o), 64'd1);
    check({tag, ".rdata"}, 64'(rdata_o), 64'(exp_rdata));
    check({tag, ".err"},   64'(err_o), 64'd0);
    @(negedge clk);
    check({tag, ".idle_done"}, 64'(done_o), 64'd0);
    check({tag, ".idle_busy"}, 64'(busy_o), 64'd0);
    $display("txn %-8s wr=%0d size=%0d addr=%h -> mem_addr=%h wstrb=%b wdata=%h rdata=%h",
             tag, wr, size, addr, mem_addr_o, exp_wstrb, exp_wdata, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; req_wr_i = 1'b0; req_size_i = 2'd0; req_unsigned_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.busy",  64'(busy_o), 64'd0);
    check("rst.done",  64'(done_o), 64'd0);
    check("rst.rqv",   64'(mem_req_valid_o), 64'd0);
    check("rst.rsprdy", 64'(mem_resp_ready_o), 64'd0);
    check("rst.addr",  64'(mem_addr_o), 64'd0);
    check("rst.rdata", 64'(rdata_o), 64'd0);
    $display("txn reset    outputs idle");

    // Byte loads: sign and zero extension from lane 3 and lane 1
    run_txn("lb",   1'b0, 2'd0, 1'b0, 16'h0003, 32'h0, 32'h80FF_1234, 0,
            16'h0000, 4'b0000, 32'h0, 32'hFFFF_FF80);
    run_txn("lbu",  1'b0, 2'd0, 1'b1, 16'h0011, 32'h0, 32'h1122_8344, 0,
            16'h0010, 4'b0000, 32'h0, 32'h0000_0083);
    // Half loads from the upper half
    run_txn("lhu",  1'b0, 2'd1, 1'b1, 16'h0002, 32'h0, 32'hBEEF_0000, 0,
            16'h0000, 4'b0000, 32'h0, 32'h0000_BEEF);
    run_txn("lh",   1'b0, 2'd1, 1'b0, 16'h0002, 32'h0, 32'hBEEF_0000, 0,
            16'h0000, 4'b0000, 32'h0, 32'hFFFF_BEEF);
    // Stores: byte and half steering
    run_txn("sb",   1'b1, 2'd0, 1'b0, 16'h0001, 32'h0000_00A5, 32'h0, 0,
            16'h0000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    run_txn("sh",   1'b1, 2'd1, 1'b0, 16'h0022, 32'h1234_ABCD, 32'h0, 0,
            16'h0020, 4'b1100, 32'hABCD_ABCD, 32'h0);
    // Stalled word store with a stray response during REQ; rdata_o stays 0 for stores
    run_txn("sw",   1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF, 32'h1234_5678, 5,
            16'h0010, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    // Size 3 on a 32-bit bus behaves as a word and is not extended
    run_txn("ld",   1'b0, 2'd3, 1'b0, 16'h0008, 32'h0, 32'h8000_0001, 0,
            16'h0008, 4'b0000, 32'h0, 32'h8000_0001);

`ifdef SR_LSU_MISALIGN_TRAP_EN
    // Misaligned word load traps without a memory request
    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = 16'h0006; req_wdata_i = '0;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("lw_mis.done",  64'(done_o), 64'd1);
    check("lw_mis.err",   64'(err_o), 64'd1);
    check("lw_mis.rqv",   64'(mem_req_valid_o), 64'd0);
    check("lw_mis.rdata", 64'(rdata_o), 64'd0);
    @(negedge clk);
    check("lw_mis.idle",  64'(done_o), 64'd0);
    $display("txn lw_mis   trapped with err_o");
`else
    // Misaligned accesses have their low bits cleared
    run_txn("lw_mis", 1'b0, 2'd2, 1'b0, 16'h0006, 32'h0, 32'hCAFE_F00D, 0,
            16'h0004, 4'b0000, 32'h0, 32'hCAFE_F00D);
    run_txn("lh_mis", 1'b0, 2'd1, 1'b0, 16'h0003, 32'h0, 32'h8001_0000, 0,
            16'h0000, 4'b0000, 32'h0, 32'hFFFF_8001);
`endif

    // Reset while waiting for a response abandons the access
    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = 1'b1; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = 16'h0044; req_wdata_i = 32'h5A5A_1234;
    @(negedge clk);
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    check("rstr.rsprdy", 64'(mem_resp_ready_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid_i = 1'b0;
    check("rstr.busy",  64'(busy_o), 64'd0);
    check("rstr.ctl",   64'({done_o, err_o, mem_req_valid_o, mem_wr_o, mem_resp_ready_o}), 64'd0);
    check("rstr.addr",  64'(mem_addr_o), 64'd0);
    check("rstr.wstrb", 64'(mem_wstrb_o), 64'd0);
    check("rstr.wdata", 64'(mem_wdata_o), 64'd0);
    check("rstr.rdata", 64'(rdata_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
      @(negedge clk);
      check("rstr.late_done", 64'(done_o), 64'd0);
      check("rstr.late_busy", 64'(busy_o), 64'd0);
    end
    mem_resp_valid_i = 1'b0;
    $display("txn rst_resp abandoned access, late response ignored");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
